// File: rtl/pic_nested_if.sv
// CPU/chipset-facing bus of the nested interrupt controller: request lines,
// INTR/INTA handshake, vector output and the two-register I/O port.
interface pic_nested_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] iIrq;
  logic               iIntAck;
  logic               oInt;
  logic               oSel;
  logic [7:0]         oData;
  logic               iIoWr;
  logic               iIoRd;
  logic               iIoAddr;
  logic [7:0]         iIoData;
  logic [7:0]         oIoData;

  modport master (
    output iIrq, iIntAck, iIoWr, iIoRd, iIoAddr, iIoData,
    input  oInt, oSel, oData, oIoData
  );

  modport slave (
    input  iIrq, iIntAck, iIoWr, iIoRd, iIoAddr, iIoData,
    output oInt, oSel, oData, oIoData
  );
endinterface

// File: rtl/pic_nested.sv
// Parametrised nested-priority interrupt controller with IMR, in-service
// nesting and specific/non-specific EOI. Define PIC_EDGE_TRIG_EN for edge-triggered requests.
module pic_nested #(
  parameter int NUM_IRQ  = 8,
  parameter int VEC_BASE = 8
) (
  input logic          iClk,
  input logic          iRstN,
  pic_nested_if.slave  bus
);

  localparam logic [7:0] VEC_BASE_B = 8'(VEC_BASE);
  localparam logic [3:0] NONE       = 4'd8;

  typedef enum logic {RD_IRR = 1'b0, RD_ISR = 1'b1} rdsel_t;

  // Index of the lowest set bit (highest priority), NONE when empty.
  function automatic logic [3:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic [3:0] idx;
    idx = NONE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [3:0] idx);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (4'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [7:0] pad8(input logic [NUM_IRQ-1:0] v);
    return 8'(v);
  endfunction

  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [7:0]         vec_q, vec_d;
  logic               sel_q, sel_d;
  logic               int_q, int_d;
  rdsel_t             rdsel_q, rdsel_d;

  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] ack_set;
  logic [NUM_IRQ-1:0] eoi_clr;
  logic [3:0]         cand;
  logic [3:0]         isr_low;
  logic [3:0]         next_cand;
  logic [3:0]         next_isr_low;
  logic               unused_rd;

  // Reads are purely combinational, so the read strobe carries no state.
  assign unused_rd = bus.iIoRd;

`ifdef PIC_EDGE_TRIG_EN
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;

  always_comb begin
    irq_prev_d = bus.iIrq;
    req        = bus.iIrq & ~irq_prev_q;
  end
`else
  always_comb begin
    req = bus.iIrq;
  end
`endif

  // Acknowledge: decided from pre-write IMR/IRR, nesting is not re-checked here.
  always_comb begin
    cand    = lowest_set(irr_q & ~imr_q);
    ack_set = '0;
    vec_d   = vec_q;
    sel_d   = bus.iIntAck;
    if (bus.iIntAck) begin
      if (cand != NONE) begin
        ack_set = onehot(cand);
        vec_d   = VEC_BASE_B + 8'(cand);
      end else begin
        vec_d   = VEC_BASE_B + 8'(NUM_IRQ - 1);
      end
    end
  end

  // Register-port writes: command decode at address 0, IMR at address 1.
  always_comb begin
    isr_low = lowest_set(isr_q);
    eoi_clr = '0;
    rdsel_d = rdsel_q;
    imr_d   = imr_q;
    if (bus.iIoWr) begin
      if (bus.iIoAddr == 1'b0) begin
        if (bus.iIoData == 8'h20) begin
          eoi_clr = onehot(isr_low);
        end else if (bus.iIoData[7:3] == 5'b01100) begin
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.iIoData[2:0] == 3'(i)) eoi_clr[i] = 1'b1;
          end
        end else if (bus.iIoData == 8'h0A) begin
          rdsel_d = RD_IRR;
        end else if (bus.iIoData == 8'h0B) begin
          rdsel_d = RD_ISR;
        end
      end else begin
        imr_d = bus.iIoData[NUM_IRQ-1:0];
      end
    end
  end

  // A new request in the ack cycle re-latches; an ack setting ISR beats an EOI on that bit.
  always_comb begin
    irr_d        = (irr_q & ~ack_set) | req;
    isr_d        = (isr_q & ~eoi_clr) | ack_set;
    next_cand    = lowest_set(irr_d & ~imr_d);
    next_isr_low = lowest_set(isr_d);
    int_d        = (next_cand != NONE) && (next_cand < next_isr_low);
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      irr_q   <= '0;
      isr_q   <= '0;
      imr_q   <= '0;
      vec_q   <= '0;
      sel_q   <= 1'b0;
      int_q   <= 1'b0;
      rdsel_q <= RD_IRR;
`ifdef PIC_EDGE_TRIG_EN
      irq_prev_q <= '0;
`endif
    end else begin
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;
      vec_q   <= vec_d;
      sel_q   <= sel_d;
      int_q   <= int_d;
      rdsel_q <= rdsel_d;
`ifdef PIC_EDGE_TRIG_EN
      irq_prev_q <= irq_prev_d;
`endif
    end
  end

  assign bus.oInt  = int_q;
  assign bus.oSel  = sel_q;
  assign bus.oData = vec_q;

  always_comb begin
    bus.oIoData = 8'h00;
    if (bus.iIoAddr) begin
      bus.oIoData = pad8(imr_q);
    end else if (rdsel_q == RD_ISR) begin
      bus.oIoData = pad8(isr_q);
    end else begin
      bus.oIoData = pad8(irr_q);
    end
  end

endmodule

// File: tb/tb_pic_nested.sv
// Directed plus randomized bench for pic_nested against a behavioural
// reference of the controller's request/service/EOI rules.
module tb_pic_nested;

  localparam int N  = 8;
  localparam int VB = 8;

  logic iClk;
  logic iRstN;

  pic_nested_if #(.NUM_IRQ(N)) ifc ();

  pic_nested #(.NUM_IRQ(N), .VEC_BASE(VB)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (ifc)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_cmp;
  int n_fail;

  // Reference state
  bit [7:0] m_irr, m_isr, m_imr, m_vec, m_prev;
  bit       m_sel, m_rd_isr;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit exp_int();
    int c;
    int l;
    c = lowest(m_irr & ~m_imr);
    l = lowest(m_isr);
    return (c >= 0) && (l < 0 || c < l);
  endfunction

  function automatic bit [7:0] exp_rd();
    if (ifc.iIoAddr) return m_imr;
    return m_rd_isr ? m_isr : m_irr;
  endfunction

  task automatic model_clock();
    bit [7:0] req;
    bit [7:0] ackbit;
    bit [7:0] eoi;
    bit [7:0] irq_now;
    int c;
    int l;
    if (!iRstN) begin
      m_irr = 0; m_isr = 0; m_imr = 0; m_vec = 0; m_prev = 0;
      m_sel = 0; m_rd_isr = 0;
      return;
    end
    irq_now = ifc.iIrq;
`ifdef PIC_EDGE_TRIG_EN
    req    = irq_now & ~m_prev;
    m_prev = irq_now;
`else
    req    = irq_now;
`endif
    c      = lowest(m_irr & ~m_imr);
    l      = lowest(m_isr);
    ackbit = 0;
    eoi    = 0;
    m_sel  = ifc.iIntAck;
    if (ifc.iIntAck) begin
      if (c >= 0) begin
        ackbit = 8'(1 << c);
        m_vec  = 8'(VB + c);
      end else begin
        m_vec  = 8'(VB + N - 1);
      end
    end
    if (ifc.iIoWr) begin
      if (!ifc.iIoAddr) begin
        if (ifc.iIoData == 8'h20) begin
          if (l >= 0) eoi = 8'(1 << l);
        end else if (ifc.iIoData[7:3] == 5'b01100) begin
          if (int'(ifc.iIoData[2:0]) < N) eoi = 8'(1 << ifc.iIoData[2:0]);
        end else if (ifc.iIoData == 8'h0A) begin
          m_rd_isr = 0;
        end else if (ifc.iIoData == 8'h0B) begin
          m_rd_isr = 1;
        end
      end else begin
        m_imr = ifc.iIoData;
      end
    end
    m_irr = (m_irr & ~ackbit) | req;
    m_isr = (m_isr & ~eoi) | ackbit;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("oInt",    {7'b0, ifc.oInt}, {7'b0, exp_int()});
    chk("oSel",    {7'b0, ifc.oSel}, {7'b0, m_sel});
    chk("oData",   ifc.oData,        m_vec);
    chk("oIoData", ifc.oIoData,      exp_rd());
  endtask

  task automatic tick();
    @(posedge iClk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic step(input bit [7:0] irq, input bit ack, input bit wr,
                      input bit addr, input bit [7:0] data);
    ifc.iIrq    = irq;
    ifc.iIntAck = ack;
    ifc.iIoWr   = wr;
    ifc.iIoRd   = ~wr;
    ifc.iIoAddr = addr;
    ifc.iIoData = data;
    tick();
  endtask

  task automatic reset_dut();
    iRstN = 1'b0;
    step(8'h00, 0, 0, 0, 8'h00);
    iRstN = 1'b1;
  endtask

  bit [7:0] r_irq;
  bit [7:0] r_data;
  bit       r_ack, r_wr, r_addr;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    iRstN  = 1'b0;
    ifc.iIrq = '0; ifc.iIntAck = 0; ifc.iIoWr = 0; ifc.iIoRd = 0;
    ifc.iIoAddr = 0; ifc.iIoData = '0;
    step(8'h00, 0, 0, 0, 8'h00);
    step(8'h00, 0, 0, 0, 8'h00);
    iRstN = 1'b1;
    step(8'h00, 0, 0, 0, 8'h00);
    chk("rst_oInt", {7'b0, ifc.oInt}, 8'h00);
    chk("rst_oSel", {7'b0, ifc.oSel}, 8'h00);
    chk("rst_oData", ifc.oData, 8'h00);
    chk("rst_irr", ifc.oIoData, 8'h00);

    // Single request, ack, vector 9
    step(8'h02, 0, 0, 0, 8'h00);
    chk("t1_int", {7'b0, ifc.oInt}, 8'h01);
    step(8'h00, 1, 0, 0, 8'h00);
    chk("t1_sel", {7'b0, ifc.oSel}, 8'h01);
    chk("t1_vec", ifc.oData, 8'h09);
    step(8'h00, 0, 1, 0, 8'h0B);
    chk("t1_isr", ifc.oIoData, 8'h02);
    chk("t1_sel_drop", {7'b0, ifc.oSel}, 8'h00);
    step(8'h00, 0, 1, 0, 8'h0A);
    chk("t1_irr", ifc.oIoData, 8'h00);

    // Nesting: 3 and 5 together
    reset_dut();
    step(8'h28, 0, 0, 0, 8'h00);
    step(8'h00, 1, 0, 0, 8'h00);
    chk("t2_vec3", ifc.oData, 8'h0B);
    chk("t2_int_blocked", {7'b0, ifc.oInt}, 8'h00);
    step(8'h00, 0, 1, 0, 8'h20);
    chk("t2_int_after_eoi", {7'b0, ifc.oInt}, 8'h01);
    step(8'h00, 1, 0, 0, 8'h00);
    chk("t2_vec5", ifc.oData, 8'h0D);

    // Masked request still latches
    reset_dut();
    step(8'h00, 0, 1, 1, 8'h04);
    step(8'h04, 0, 0, 0, 8'h00);
    chk("t3_int_masked", {7'b0, ifc.oInt}, 8'h00);
    chk("t3_irr", ifc.oIoData, 8'h04);
    step(8'h00, 0, 1, 1, 8'h00);
    chk("t3_int_unmasked", {7'b0, ifc.oInt}, 8'h01);

    // Spurious ack
    reset_dut();
    step(8'h00, 1, 0, 0, 8'h00);
    chk("t4_spurious", ifc.oData, 8'h0F);
    step(8'h00, 0, 1, 0, 8'h0B);
    chk("t4_isr", ifc.oIoData, 8'h00);

    // EOI and ack collide on the same bit; non-specific EOI on lowest bit
    reset_dut();
    step(8'h10, 0, 0, 0, 8'h00);
    step(8'h00, 1, 0, 0, 8'h00);
    step(8'h10, 0, 0, 0, 8'h00);
    step(8'h00, 1, 1, 0, 8'h64);
    step(8'h00, 0, 1, 0, 8'h0B);
    chk("t5_set_wins", ifc.oIoData, 8'h10);
    step(8'h02, 0, 0, 0, 8'h00);
    step(8'h00, 1, 0, 0, 8'h00);
    chk("t5_isr12", ifc.oIoData, 8'h12);
    step(8'h00, 0, 1, 0, 8'h20);
    chk("t5_nseoi", ifc.oIoData, 8'h10);

    // Line 0 held high across two acks
    reset_dut();
    step(8'h01, 0, 0, 0, 8'h00);
    step(8'h01, 1, 0, 0, 8'h00);
    chk("t6_vec_first", ifc.oData, 8'h08);
    step(8'h01, 0, 0, 0, 8'h00);
    step(8'h01, 0, 1, 0, 8'h20);
    step(8'h01, 0, 0, 0, 8'h00);
    step(8'h01, 1, 0, 0, 8'h00);
`ifdef PIC_EDGE_TRIG_EN
    chk("t6_vec_second", ifc.oData, 8'h0F);
`else
    chk("t6_vec_second", ifc.oData, 8'h08);
`endif
    step(8'h01, 0, 1, 0, 8'h20);
    step(8'h01, 0, 0, 0, 8'h00);
    step(8'h01, 0, 0, 0, 8'h00);
    step(8'h01, 0, 0, 0, 8'h00);

    // Reset asserted during an ack
    step(8'h00, 0, 0, 0, 8'h00);
    ifc.iIntAck = 1'b1;
    #2 iRstN = 1'b0;
    @(posedge iClk);
    model_clock();
    #1;
    check_all();
    chk("rst_mid_ack_sel", {7'b0, ifc.oSel}, 8'h00);
    chk("rst_mid_ack_vec", ifc.oData, 8'h00);
    ifc.iIntAck = 1'b0;
    iRstN = 1'b1;
    step(8'h00, 0, 0, 0, 8'h00);
    chk("rst_mid_ack_sel2", {7'b0, ifc.oSel}, 8'h00);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) reset_dut();
      r_irq  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      r_ack  = ($urandom_range(0, 5) == 0);
      r_wr   = ($urandom_range(0, 3) == 0);
      r_addr = 1'($urandom_range(0, 1));
      if (r_addr) begin
        r_data = 8'($urandom) & 8'($urandom);
      end else begin
        case ($urandom_range(0, 5))
          0, 5:    r_data = 8'h20;
          1:       r_data = 8'h60 | 8'($urandom_range(0, 7));
          2:       r_data = 8'h0A;
          3:       r_data = 8'h0B;
          default: r_data = 8'($urandom);
        endcase
      end
      step(r_irq, r_ack, r_wr, r_addr, r_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
